// File: rtl/fp16_pkg.sv
// Shared constants, FSM state type and result record for the binary16
// normalize/round back end.
package fp16_pkg;

   localparam int MANT_W  = 14;
   localparam int EXP_W   = 5;
   localparam int FRAC_W  = 10;
   localparam int EXP_MAX = 31;
   localparam int RES_W   = 1 + EXP_W + FRAC_W;

   // Rounding bit positions within the raw mantissa
   localparam int KEEP_LSB = 3;
   localparam int G_POS    = 2;
   localparam int R_POS    = 1;
   localparam int S_POS    = 0;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      ROUND,
      DONE
   } state_t;

   typedef struct packed {
      logic [RES_W-1:0] bits;
      logic             ovf;
      logic             inexact;
   } round_t;

endpackage

// File: rtl/lzc14.sv
// 14-bit leading-zero counter; an all-zero input yields 14.
module lzc14 (
   input  logic [13:0] value,
   output logic [3:0]  count
);

   // Scanning upward lets the most significant set bit win
   always_comb begin
      count = 4'd14;
      for (int i = 0; i < 14; i++) begin
         if (value[i]) count = 4'(13 - i);
      end
   end

endmodule

// File: rtl/normalize_and_round.sv
// Left-normalizes a raw adder mantissa, rounds to nearest-even and packs binary16.
// Define NORM_FAST_EN for a single-cycle LZC-based normalize instead of 1 bit/cycle.
module normalize_and_round #(
   parameter int MANT_W = fp16_pkg::MANT_W,
   parameter int EXP_W  = fp16_pkg::EXP_W,
   parameter int FRAC_W = fp16_pkg::FRAC_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    sign_in,
   input  logic [MANT_W-1:0]       mant_in,
   input  logic [EXP_W-1:0]        exp_in,
   input  logic                    sticky_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [EXP_W+FRAC_W:0]   result,
   output logic                    flag_ovf,
   output logic                    flag_inexact
);
   import fp16_pkg::*;

   state_t                 state_q, state_d;
   logic                   sign_q;
   logic [MANT_W-1:0]      mant_q;
   logic [EXP_W:0]         exp_q;
   logic                   sticky_q;
   logic [EXP_W+FRAC_W:0]  result_q;
   logic                   ovf_q;
   logic                   inexact_q;
   logic                   shift_en;
   round_t                 rnd;

   function automatic round_t round_pack(input logic sign, input logic [13:0] mant,
                                         input logic [5:0] exp, input logic sticky);
      round_t      rt;
      logic [10:0] keep;
      logic        g, r, s, inc, hidden;
      logic [11:0] sum;
      logic [5:0]  exp_f;
      logic [9:0]  frac;
      keep   = mant[13:KEEP_LSB];
      g      = mant[G_POS];
      r      = mant[R_POS];
      s      = mant[S_POS] | sticky;
      inc    = g & (r | s | keep[0]);
      sum    = {1'b0, keep} + {11'b0, inc};
      exp_f  = exp;
      frac   = sum[9:0];
      hidden = sum[10];
      // Rounding carried out of the significand: renormalize by one
      if (sum[11]) begin
         exp_f  = exp + 6'd1;
         frac   = '0;
         hidden = 1'b1;
      end
      rt.inexact = g | r | s;
      rt.ovf     = 1'b0;
      if (mant == '0) begin
         rt.bits = {sign, 15'h0};
      end else if (exp_f >= 6'(EXP_MAX)) begin
         rt.bits = {sign, 5'h1F, 10'h0};
         rt.ovf  = 1'b1;
      end else if (!hidden) begin
         rt.bits = {sign, 5'h0, frac};
      end else begin
         rt.bits = {sign, exp_f[4:0], frac};
      end
      return rt;
   endfunction

   assign shift_en = (mant_q != '0) && !mant_q[MANT_W-1] && (exp_q > 6'd1);
   assign rnd      = round_pack(sign_q, mant_q, exp_q, sticky_q);

`ifdef NORM_FAST_EN
   logic [3:0]     lz, shamt;
   logic [EXP_W:0] lim;

   lzc14 u_lzc (
      .value (mant_q),
      .count (lz)
   );

   // Shift no further than the exponent allows; stopping at exp==1 leaves a denormal
   always_comb begin
      lim   = exp_q - 6'd1;
      shamt = lz;
      if (mant_q == '0)          shamt = '0;
      else if ({2'b0, lz} > lim) shamt = lim[3:0];
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = SHIFT;
         end
         SHIFT: begin
`ifdef NORM_FAST_EN
            state_d = ROUND;
`else
            if (!shift_en) state_d = ROUND;
`endif
         end
         ROUND: state_d = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---- operand capture / normalize / round-and-pack registers ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign_q    <= 1'b0;
         mant_q    <= '0;
         exp_q     <= '0;
         sticky_q  <= 1'b0;
         result_q  <= '0;
         ovf_q     <= 1'b0;
         inexact_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  sign_q   <= sign_in;
                  mant_q   <= mant_in;
                  exp_q    <= (exp_in == '0) ? 6'd1 : {1'b0, exp_in};
                  sticky_q <= sticky_in;
               end
            end
            SHIFT: begin
`ifdef NORM_FAST_EN
               mant_q <= mant_q << shamt;
               exp_q  <= exp_q - {2'b0, shamt};
`else
               if (shift_en) begin
                  mant_q <= {mant_q[MANT_W-2:0], 1'b0};
                  exp_q  <= exp_q - 6'd1;
               end
`endif
            end
            ROUND: begin
               result_q  <= rnd.bits;
               ovf_q     <= rnd.ovf;
               inexact_q <= rnd.inexact;
            end
            default: ;
         endcase
      end
   end

   assign result       = result_q;
   assign flag_ovf     = ovf_q;
   assign flag_inexact = inexact_q;

endmodule

// File: tb/tb_normalize_and_round.sv
// Randomized and directed bench for normalize_and_round against an arithmetic
// round-to-nearest-even model of binary16 packing.
module tb_normalize_and_round;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        sign_in = 1'b0;
   logic [13:0] mant_in = '0;
   logic [4:0]  exp_in = '0;
   logic        sticky_in = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] result;
   logic        flag_ovf;
   logic        flag_inexact;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   normalize_and_round dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .sign_in      (sign_in),
      .mant_in      (mant_in),
      .exp_in       (exp_in),
      .sticky_in    (sticky_in),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result       (result),
      .flag_ovf     (flag_ovf),
      .flag_inexact (flag_inexact)
   );

   // Value = m * 2^(e-...) with m scaled so bit13 is the leading position; the
   // shift is chosen from the magnitude, rounding from integer quotient/remainder.
   function automatic void model(input logic s, input logic [13:0] m, input logic [4:0] ein,
                                 input logic st, output logic [15:0] res, output logic ovf,
                                 output logic inx, output int sh);
      int e, n, q, rem, msb;
      e  = (ein == 5'd0) ? 1 : int'(ein);
      sh = 0;
      if (m != 14'd0) begin
         msb = 0;
         for (int i = 0; i < 14; i++) if (m[i]) msb = i;
         sh = 13 - msb;
         if (sh > e - 1) sh = e - 1;
      end
      n   = int'(m) * (1 << sh);
      e   = e - sh;
      q   = n / 8;
      rem = (n % 8) * 2 + int'(st);
      inx = (rem != 0);
      if (rem > 8 || (rem == 8 && (q % 2) == 1)) q = q + 1;
      if (q >= 2048) begin
         q = q / 2;
         e = e + 1;
      end
      ovf = 1'b0;
      if (n == 0)          res = {s, 15'h0};
      else if (e >= 31)    begin res = {s, 5'h1F, 10'h0}; ovf = 1'b1; end
      else if (q < 1024)   res = {s, 5'h0, 10'(q)};
      else                 res = {s, 5'(e), 10'(q - 1024)};
   endfunction

   function automatic int want_lat(input int sh);
`ifdef NORM_FAST_EN
      return 2 + 0 * sh;
`else
      return 2 + sh;
`endif
   endfunction

   // Drives one operand and collects the response; latency counts clock edges after acceptance.
   task automatic run_op(input logic s, input logic [13:0] m, input logic [4:0] e, input logic st,
                         output logic [15:0] res, output logic ovf, output logic inx, output int lat);
      @(negedge clk);
      sign_in = s; mant_in = m; exp_in = e; sticky_in = st; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      res = result; ovf = flag_ovf; inx = flag_inexact;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
      total_cnt++; if (result !== 16'h0) $display("FAIL reset_result got %h want 0000", result); else pass_cnt++;
      total_cnt++; if (flag_ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", flag_ovf); else pass_cnt++;
      total_cnt++; if (flag_inexact !== 1'b0) $display("FAIL reset_inexact got %b want 0", flag_inexact); else pass_cnt++;
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [13:0] m   [10] = '{14'h2000, 14'h1000, 14'h2004, 14'h200C, 14'h3FFC,
                                14'h0000, 14'h0400, 14'h0400, 14'h2000, 14'h1FFC};
      logic [4:0]  e   [10] = '{5'd16, 5'd16, 5'd16, 5'd16, 5'd30, 5'd16, 5'd1, 5'd0, 5'd31, 5'd1};
      logic        sg  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [15:0] w   [10] = '{16'h4000, 16'h3C00, 16'h4000, 16'h4002, 16'h7C00,
                                16'h8000, 16'h0080, 16'h0080, 16'h7C00, 16'h0400};
      logic        wo  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic        wx  [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      int          wsh [10] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
      logic [15:0] r;
      logic        o, x;
      int          lat;
      for (int i = 0; i < 10; i++) begin
         run_op(sg[i], m[i], e[i], 1'b0, r, o, x, lat);
         total_cnt++; if (r !== w[i]) $display("FAIL dir%0d_result got %h want %h", i, r, w[i]); else pass_cnt++;
         total_cnt++; if (o !== wo[i]) $display("FAIL dir%0d_ovf got %b want %b", i, o, wo[i]); else pass_cnt++;
         total_cnt++; if (x !== wx[i]) $display("FAIL dir%0d_inexact got %b want %b", i, x, wx[i]); else pass_cnt++;
         total_cnt++; if (lat != want_lat(wsh[i])) $display("FAIL dir%0d_latency got %0d want %0d", i, lat, want_lat(wsh[i])); else pass_cnt++;
      end
   endtask

   task automatic test_random();
      logic [15:0] r, wr;
      logic        o, x, wo, wx, s, st;
      logic [13:0] m;
      logic [4:0]  e;
      int          lat, sh;
      for (int i = 0; i < 60; i++) begin
         s  = 1'($urandom);
         st = 1'($urandom);
         m  = 14'($urandom) >> $urandom_range(0, 13);
         e  = 5'($urandom_range(0, 31));
         model(s, m, e, st, wr, wo, wx, sh);
         run_op(s, m, e, st, r, o, x, lat);
         total_cnt++; if (r !== wr) $display("FAIL rnd_result m=%h e=%0d st=%b got %h want %h", m, e, st, r, wr); else pass_cnt++;
         total_cnt++; if (o !== wo) $display("FAIL rnd_ovf m=%h e=%0d got %b want %b", m, e, o, wo); else pass_cnt++;
         total_cnt++; if (x !== wx) $display("FAIL rnd_inexact m=%h e=%0d got %b want %b", m, e, x, wx); else pass_cnt++;
         total_cnt++; if (lat != want_lat(sh)) $display("FAIL rnd_latency m=%h e=%0d got %0d want %0d", m, e, lat, want_lat(sh)); else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] r, wr;
      logic        o, x, wo, wx, s;
      logic [13:0] m;
      logic [4:0]  e;
      int          lat, sh;
      for (int i = 0; i < 4; i++) begin
         s = 1'($urandom);
         m = 14'($urandom) >> $urandom_range(0, 6);
         e = 5'($urandom_range(2, 29));
         model(s, m, e, 1'b0, wr, wo, wx, sh);
         run_op(s, m, e, 1'b0, r, o, x, lat);
         total_cnt++; if (r !== wr) $display("FAIL b2b%0d_result got %h want %h", i, r, wr); else pass_cnt++;
         total_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL b2b%0d_idle got in_ready=%b out_valid=%b want 1/0", i, in_ready, out_valid);
         else pass_cnt++;
      end
   endtask

   task automatic test_backpressure();
      int lat;
      @(negedge clk);
      sign_in = 1'b0; mant_in = 14'h3FFC; exp_in = 5'd30; sticky_in = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid_timeout got %b want 1", out_valid); else pass_cnt++;
      // A competing operand during DONE must be ignored
      sign_in = 1'b1; mant_in = 14'h2000; exp_in = 5'd16; in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total_cnt++; if (result !== 16'h7C00 || out_valid !== 1'b1)
            $display("FAIL bp_hold%0d got result=%h out_valid=%b want 7c00/1", c, result, out_valid);
         else pass_cnt++;
         total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready%0d got %b want 0", c, in_ready); else pass_cnt++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      total_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL bp_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      else pass_cnt++;
      total_cnt++; if (flag_ovf !== 1'b1 || flag_inexact !== 1'b1)
         $display("FAIL bp_flags got ovf=%b inexact=%b want 1/1", flag_ovf, flag_inexact);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_shift();
      logic [15:0] r;
      logic        o, x;
      int          lat;
      @(negedge clk);
      sign_in = 1'b0; mant_in = 14'h0001; exp_in = 5'd20; sticky_in = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready got %b want 1", in_ready); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid got %b want 0", out_valid); else pass_cnt++;
      total_cnt++; if (result !== 16'h0) $display("FAIL rstmid_result got %h want 0000", result); else pass_cnt++;
      total_cnt++; if (flag_ovf !== 1'b0 || flag_inexact !== 1'b0)
         $display("FAIL rstmid_flags got ovf=%b inexact=%b want 0/0", flag_ovf, flag_inexact);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      run_op(1'b0, 14'h1000, 5'd16, 1'b0, r, o, x, lat);
      total_cnt++; if (r !== 16'h3C00) $display("FAIL rstmid_after got %h want 3c00", r); else pass_cnt++;
      total_cnt++; if (lat != want_lat(1)) $display("FAIL rstmid_after_latency got %0d want %0d", lat, want_lat(1)); else pass_cnt++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_shift();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
